am2901_useq: RTL and testbench
==============================

// Module: am2901_useq
// PURPOSE
//  Microprogram sequencer (Am2910-style subset) for the Am2901 slice datapath.
//  Each cycle it registers the next control-store address from a 4-bit next-address op,
//  a condition code, a branch/count literal and a map address.
//  The control-store word at uaddr supplies the slice opcode i[8:0], the A/B addresses
//  and this block's op/cc/d. Internal state: return-address LIFO and a loop counter.
// PARAMETERS
//  ADDR_W       8   width of microaddress, branch literal d, map_addr and loop counter
//  STACK_DEPTH  4   return-address LIFO entries (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  hold         in   1       1 = freeze all state (uaddr, counter, stack, err)
//  op           in   4       next-address op (table below)
//  cc           in   1       condition, 1 = pass
//  d            in   ADDR_W  branch target / counter load value
//  map_addr     in   ADDR_W  macro-opcode mapping address
//  uaddr        out  ADDR_W  registered control-store address
//  stack_full   out  1       LIFO holds STACK_DEPTH entries
//  stack_empty  out  1       LIFO holds 0 entries
//  cnt_zero     out  1       loop counter == 0
//  err          out  1       sticky: push on full or pop/read on empty
// BEHAVIOUR
//  Reset (async, rst_n=0): uaddr=0, cnt=0, sp=0, err=0; stack_empty=1, stack_full=0, cnt_zero=1.
//  Deassertion is synchronised externally; first update occurs on the first clk edge with rst_n=1.
//  Flags are combinational decodes of the sp and cnt registers.
//  hold=1: no register changes, uaddr stable. hold overrides every op, including JZ.
//  pc1 = uaddr+1 mod 2^ADDR_W (2^ADDR_W-1 wraps to 0). TOS = top entry; 0 when empty.
//  Ops (hold=0); uaddr, cnt and stack update together at the edge, 1-cycle latency:
//   0 JZ    uaddr<=0; sp<=0; err<=0; cnt unchanged
//   1 CJS   cc ? (push pc1, uaddr<=d) : uaddr<=pc1
//   2 JMAP  uaddr<=map_addr
//   3 CJP   cc ? uaddr<=d : uaddr<=pc1
//   4 PUSH  push pc1; if cc then cnt<=d; uaddr<=pc1
//   5 RFCT  cnt!=0 ? (cnt<=cnt-1, uaddr<=TOS) : (pop, uaddr<=pc1)
//   6 CRTN  cc ? (uaddr<=TOS, pop) : uaddr<=pc1
//   7 LDCT  cnt<=d; uaddr<=pc1
//   8 CONT  uaddr<=pc1
//   9 LOOP  cc ? (pop, uaddr<=pc1) : uaddr<=TOS
//   10-15   behave as CONT; no err
//  Push on full: stack unchanged, err<=1; the op's uaddr/cnt effect still happens.
//  Pop on empty: sp stays 0, err<=1, uaddr uses TOS=0.
//  Reading TOS while empty (RFCT with cnt!=0, LOOP with cc=0) also sets err.
//  cnt never wraps in RFCT; the cnt==0 branch pops instead of decrementing.
//  Counter and stack are independent; a single op never both pushes and pops.
//  Reset mid-sequence discards stack and counter immediately, without waiting for clk.
// TESTING
//  T1 reset, then 5x CONT -> uaddr 0,1,2,3,4,5; flags empty=1, full=0, cnt_zero=1, err=0
//  T2 uaddr=0x10, CJS cc=1 d=0x40 -> uaddr=0x40, stack=[0x11];
//     then CRTN cc=1 -> uaddr=0x11, stack_empty=1
//  T3 LDCT d=2 at 0x20, PUSH cc=0 at 0x21, RFCT at 0x22 x3 ->
//     uaddr 0x22,0x22,0x22 then 0x23; cnt 2->1->0; stack_empty=1 at end
//  T4 5x CJS cc=1 (DEPTH=4) -> full=1 after 4th; 5th jumps, err=1, stack unchanged;
//     4x CRTN -> empty; JZ -> uaddr=0, err=0
//  T5 hold=1 for 3 cycles during CJP cc=1 d=0x80 -> uaddr frozen; release -> uaddr=0x80
//  T6 uaddr=0xFF, CONT -> 0x00; rst_n pulsed low mid-RFCT loop -> uaddr=0, cnt=0 with no clk edge

Source files
------------

// File: rtl/am2901_useq.sv
// Am2910-style microprogram sequencer for the Am2901 slice datapath: next-address select,
// return-address LIFO and loop counter, all registered with one-cycle latency.
module am2901_useq #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [3:0]        op,
  input  logic              cc,
  input  logic [ADDR_W-1:0] d,
  input  logic [ADDR_W-1:0] map_addr,
  output logic [ADDR_W-1:0] uaddr,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              cnt_zero,
  output logic              err
);

  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);
  localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

  localparam logic [3:0] OpJz   = 4'd0;
  localparam logic [3:0] OpCjs  = 4'd1;
  localparam logic [3:0] OpJmap = 4'd2;
  localparam logic [3:0] OpCjp  = 4'd3;
  localparam logic [3:0] OpPush = 4'd4;
  localparam logic [3:0] OpRfct = 4'd5;
  localparam logic [3:0] OpCrtn = 4'd6;
  localparam logic [3:0] OpLdct = 4'd7;
  localparam logic [3:0] OpLoop = 4'd9;

  logic [ADDR_W-1:0] uaddr_q, uaddr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [SpW-1:0]    sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0] pc1;
  logic [ADDR_W-1:0] tos;
  logic              do_push, do_pop, rd_tos, do_clr;
  logic              full, empty;

  assign full  = (sp_q == SpFull);
  assign empty = (sp_q == '0);
  assign pc1   = uaddr_q + ADDR_W'(1);

  // Top of stack reads as zero when the LIFO is empty.
  always_comb begin
    tos = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SpW'(i + 1)) tos = stack_q[i];
    end
  end

  always_comb begin
    uaddr_d = uaddr_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    rd_tos  = 1'b0;
    do_clr  = 1'b0;

    if (!hold) begin
      uaddr_d = pc1;
      case (op)
        OpJz: begin
          uaddr_d = '0;
          do_clr  = 1'b1;
        end
        OpCjs: begin
          if (cc) begin
            do_push = 1'b1;
            uaddr_d = d;
          end
        end
        OpJmap: uaddr_d = map_addr;
        OpCjp:  if (cc) uaddr_d = d;
        OpPush: begin
          do_push = 1'b1;
          if (cc) cnt_d = d;
        end
        OpRfct: begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - ADDR_W'(1);
            uaddr_d = tos;
            rd_tos  = 1'b1;
          end else begin
            do_pop = 1'b1;
          end
        end
        OpCrtn: begin
          if (cc) begin
            uaddr_d = tos;
            do_pop  = 1'b1;
          end
        end
        OpLdct: cnt_d = d;
        OpLoop: begin
          if (cc) begin
            do_pop = 1'b1;
          end else begin
            uaddr_d = tos;
            rd_tos  = 1'b1;
          end
        end
        default: ;
      endcase

      if (do_push) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          sp_d = sp_q + SpW'(1);
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SpW'(i)) stack_d[i] = pc1;
          end
        end
      end
      if (do_pop) begin
        if (empty) err_d = 1'b1;
        else       sp_d  = sp_q - SpW'(1);
      end
      if (rd_tos && empty) err_d = 1'b1;
      if (do_clr) begin
        sp_d  = '0;
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uaddr_q <= '0;
      cnt_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      uaddr_q <= uaddr_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign uaddr       = uaddr_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign cnt_zero    = (cnt_q == '0);
  assign err         = err_q;

endmodule

// File: tb/tb_am2901_useq.sv
// Directed vector bench for am2901_useq: one table of ops with hand-computed results,
// plus a hand-written asynchronous-reset sequence.
module tb_am2901_useq;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic [3:0] op;
  logic       cc;
  logic [7:0] d;
  logic [7:0] map_addr;
  logic [7:0] uaddr;
  logic       stack_full, stack_empty, cnt_zero, err;

  int checks = 0;
  int errors = 0;

  am2901_useq #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .op         (op),
    .cc         (cc),
    .d          (d),
    .map_addr   (map_addr),
    .uaddr      (uaddr),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .cnt_zero   (cnt_zero),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       hold;
    logic [3:0] op;
    logic       cc;
    logic [7:0] d;
    logic [7:0] map_addr;
    logic [7:0] e_uaddr;
    logic       e_empty;
    logic       e_full;
    logic       e_cz;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic h, input logic [3:0] o, input logic c,
                     input logic [7:0] dd, input logic [7:0] m, input logic [7:0] eu,
                     input logic ee, input logic ef, input logic ez, input logic er);
    vec_t v;
    v.name = name; v.hold = h; v.op = o; v.cc = c; v.d = dd; v.map_addr = m;
    v.e_uaddr = eu; v.e_empty = ee; v.e_full = ef; v.e_cz = ez; v.e_err = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] eu, input logic ee,
                       input logic ef, input logic ez, input logic er);
    checks++;
    if (uaddr !== eu || stack_empty !== ee || stack_full !== ef || cnt_zero !== ez ||
        err !== er) begin
      errors++;
      $display("FAIL %s: got uaddr=%h empty=%b full=%b cz=%b err=%b, expected uaddr=%h empty=%b full=%b cz=%b err=%b",
               name, uaddr, stack_empty, stack_full, cnt_zero, err, eu, ee, ef, ez, er);
    end
  endtask

  task automatic step(input logic h, input logic [3:0] o, input logic c, input logic [7:0] dd,
                      input logic [7:0] m);
    hold = h; op = o; cc = c; d = dd; map_addr = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; op = 4'd8; cc = 1'b0; d = '0; map_addr = '0;

    //   name          h  op  cc d      map    uaddr  emp full cz err
    // T1
    add("t1_cont1",    0, 8,  0, 8'h00, 8'h00, 8'h01, 1, 0, 1, 0);
    add("t1_cont2",    0, 8,  0, 8'h00, 8'h00, 8'h02, 1, 0, 1, 0);
    add("t1_cont3",    0, 8,  0, 8'h00, 8'h00, 8'h03, 1, 0, 1, 0);
    add("t1_cont4",    0, 8,  0, 8'h00, 8'h00, 8'h04, 1, 0, 1, 0);
    add("t1_cont5",    0, 8,  0, 8'h00, 8'h00, 8'h05, 1, 0, 1, 0);
    // T2
    add("cjp_to_10",   0, 3,  1, 8'h10, 8'h00, 8'h10, 1, 0, 1, 0);
    add("t2_cjs",      0, 1,  1, 8'h40, 8'h00, 8'h40, 0, 0, 1, 0);
    add("t2_crtn",     0, 6,  1, 8'h00, 8'h00, 8'h11, 1, 0, 1, 0);
    // T3
    add("cjp_to_20",   0, 3,  1, 8'h20, 8'h00, 8'h20, 1, 0, 1, 0);
    add("t3_ldct",     0, 7,  0, 8'h02, 8'h00, 8'h21, 1, 0, 0, 0);
    add("t3_push",     0, 4,  0, 8'h77, 8'h00, 8'h22, 0, 0, 0, 0);
    add("t3_rfct1",    0, 5,  0, 8'h00, 8'h00, 8'h22, 0, 0, 0, 0);
    add("t3_rfct2",    0, 5,  0, 8'h00, 8'h00, 8'h22, 0, 0, 1, 0);
    add("t3_rfct3",    0, 5,  0, 8'h00, 8'h00, 8'h23, 1, 0, 1, 0);
    // Untaken conditionals, map, reserved op
    add("cjp_nc",      0, 3,  0, 8'h99, 8'h00, 8'h24, 1, 0, 1, 0);
    add("jmap",        0, 2,  0, 8'h99, 8'h30, 8'h30, 1, 0, 1, 0);
    add("cjs_nc",      0, 1,  0, 8'h99, 8'h00, 8'h31, 1, 0, 1, 0);
    add("crtn_nc",     0, 6,  0, 8'h99, 8'h00, 8'h32, 1, 0, 1, 0);
    add("op12",        0, 12, 1, 8'h99, 8'h55, 8'h33, 1, 0, 1, 0);
    // LOOP
    add("push_ld0",    0, 4,  1, 8'h00, 8'h00, 8'h34, 0, 0, 1, 0);
    add("loop_nc",     0, 9,  0, 8'h00, 8'h00, 8'h34, 0, 0, 1, 0);
    add("loop_c",      0, 9,  1, 8'h00, 8'h00, 8'h35, 1, 0, 1, 0);
    // T4
    add("t4_cjs1",     0, 1,  1, 8'h50, 8'h00, 8'h50, 0, 0, 1, 0);
    add("t4_cjs2",     0, 1,  1, 8'h60, 8'h00, 8'h60, 0, 0, 1, 0);
    add("t4_cjs3",     0, 1,  1, 8'h70, 8'h00, 8'h70, 0, 0, 1, 0);
    add("t4_cjs4",     0, 1,  1, 8'h78, 8'h00, 8'h78, 0, 1, 1, 0);
    add("t4_cjs5",     0, 1,  1, 8'h7C, 8'h00, 8'h7C, 0, 1, 1, 1);
    add("t4_crtn1",    0, 6,  1, 8'h00, 8'h00, 8'h71, 0, 0, 1, 1);
    add("t4_crtn2",    0, 6,  1, 8'h00, 8'h00, 8'h61, 0, 0, 1, 1);
    add("t4_crtn3",    0, 6,  1, 8'h00, 8'h00, 8'h51, 0, 0, 1, 1);
    add("t4_crtn4",    0, 6,  1, 8'h00, 8'h00, 8'h36, 1, 0, 1, 1);
    add("t4_jz",       0, 0,  0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0);
    // Empty-stack errors; JZ leaves the counter alone
    add("crtn_empty",  0, 6,  1, 8'h00, 8'h00, 8'h00, 1, 0, 1, 1);
    add("jz_clr",      0, 0,  0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0);
    add("ldct3",       0, 7,  0, 8'h03, 8'h00, 8'h01, 1, 0, 0, 0);
    add("rfct_empty",  0, 5,  0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
    add("jz_keep_cnt", 0, 0,  0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
    // T5
    add("t5_hold1",    1, 3,  1, 8'h80, 8'h00, 8'h00, 1, 0, 0, 0);
    add("t5_hold2",    1, 3,  1, 8'h80, 8'h00, 8'h00, 1, 0, 0, 0);
    add("t5_hold3",    1, 3,  1, 8'h80, 8'h00, 8'h00, 1, 0, 0, 0);
    add("t5_release",  0, 3,  1, 8'h80, 8'h00, 8'h80, 1, 0, 0, 0);
    add("hold_jz",     1, 0,  0, 8'h00, 8'h00, 8'h80, 1, 0, 0, 0);
    // T6 wrap
    add("cjp_to_ff",   0, 3,  1, 8'hFF, 8'h00, 8'hFF, 1, 0, 0, 0);
    add("t6_wrap",     0, 8,  0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);

    #2;
    check("reset_state", 8'h00, 1, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", 8'h00, 1, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].hold, vecs[i].op, vecs[i].cc, vecs[i].d, vecs[i].map_addr);
      check(vecs[i].name, vecs[i].e_uaddr, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_cz,
            vecs[i].e_err);
    end

    // Async reset in the middle of an RFCT loop with a live stack and counter
    step(0, 7, 0, 8'h05, 8'h00);
    check("t6_ldct", 8'h01, 1, 0, 0, 0);
    step(0, 4, 0, 8'h00, 8'h00);
    check("t6_push", 8'h02, 0, 0, 0, 0);
    step(0, 5, 0, 8'h00, 8'h00);
    check("t6_rfct", 8'h02, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_rst", 8'h00, 1, 0, 1, 0);
    @(negedge clk);
    check("t6_rst_held", 8'h00, 1, 0, 1, 0);
    rst_n = 1'b1;
    step(0, 8, 0, 8'h00, 8'h00);
    check("t6_after_rst", 8'h01, 1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
